// File: rtl/div_unit_pkg.sv
`timescale 1ns/1ps
// div_unit_pkg
//   Shared widths, iteration counts, FSM state type and a sign-extension
//   helper for the iterative RV64M divider (div_unit) and its step (div_step).
package div_unit_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ITER_D = 64;
    localparam int unsigned ITER_W = 32;
    localparam int unsigned CNT_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    function automatic logic [DATA_W-1:0] sext_word(input logic [WORD_W-1:0] v);
        return {{(DATA_W-WORD_W){v[WORD_W-1]}}, v};
    endfunction

endpackage

// File: rtl/div_unit_step.sv
`timescale 1ns/1ps
// div_step
//   One combinational restoring-division iteration.
//   Ports:
//     rem_i  partial remainder (always < dvs_i)
//     dvd_i  dividend bits still to consume (MSB first); quotient bits
//            accumulate at the LSB end
//     dvs_i  divisor magnitude
//     rem_o  next partial remainder
//     dvd_o  dvd_i shifted left with the new quotient bit inserted
//     q_o    quotient bit produced by this step
module div_step
    import div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] dvd_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] dvd_o,
    output logic              q_o
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;

    always_comb begin
        shifted = {rem_i, dvd_i[DATA_W-1]};
        // Because rem_i < dvs_i, a successful subtraction always fits in
        // DATA_W bits, so the low-order difference is exact.
        q_o     = (shifted >= {1'b0, dvs_i});
        diff    = shifted[DATA_W-1:0] - dvs_i;
        rem_o   = q_o ? diff : shifted[DATA_W-1:0];
        dvd_o   = {dvd_i[DATA_W-2:0], q_o};
    end

endmodule

// File: rtl/div_unit.sv
`timescale 1ns/1ps
// div_unit
//   Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
//   W variants. Stalls the pipeline while iterating and presents quotient
//   and remainder with a one-cycle done pulse.
//   Optional feature macro: DIV_ZERO_SHORTCUT_EN -- divide-by-zero and
//   signed overflow complete one cycle after the request instead of
//   running the full iteration count.
//   Ports:
//     clk_i        core clock, rising edge
//     rstn_i       asynchronous active-low reset
//     kill_i       flush; aborts any operation, wins over request_i
//     request_i    start a division (sampled only in IDLE)
//     signed_op_i  1 = DIV/REM, 0 = DIVU/REMU
//     word_op_i    1 = 32-bit W variant
//     src1_i       dividend
//     src2_i       divisor
//     quo_o        quotient (valid with done_o)
//     rmd_o        remainder (valid with done_o)
//     stall_o      high while iterating
//     done_o       one-cycle result-valid pulse
module div_unit
    import div_unit_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              kill_i,
    input  logic              request_i,
    input  logic              signed_op_i,
    input  logic              word_op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [DATA_W-1:0] quo_o,
    output logic [DATA_W-1:0] rmd_o,
    output logic              stall_o,
    output logic              done_o
);

    state_t state_q, state_d;

    logic [DATA_W-1:0] rem_q, dvd_q, dvs_q, orig_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              quo_neg_q, rmd_neg_q, word_q, zero_q, ovf_q;
    logic [DATA_W-1:0] quo_q, rmd_q;

    logic              accept;
    logic [DATA_W-1:0] a_eff, b_eff, a_abs, b_abs, dvd_init;
    logic              a_neg, b_neg, div_zero, ovf;

    logic [DATA_W-1:0] step_rem, step_dvd;
    logic              step_q;

    logic [DATA_W-1:0] quo_raw, quo_s, rmd_s, quo_sel, rmd_sel, quo_fix, rmd_fix;

    // Operand preparation at accept time.
    always_comb begin
        if (word_op_i) begin
            a_eff = signed_op_i ? sext_word(src1_i[WORD_W-1:0]) : {{(DATA_W-WORD_W){1'b0}}, src1_i[WORD_W-1:0]};
            b_eff = signed_op_i ? sext_word(src2_i[WORD_W-1:0]) : {{(DATA_W-WORD_W){1'b0}}, src2_i[WORD_W-1:0]};
        end else begin
            a_eff = src1_i;
            b_eff = src2_i;
        end
        a_neg    = signed_op_i & a_eff[DATA_W-1];
        b_neg    = signed_op_i & b_eff[DATA_W-1];
        a_abs    = a_neg ? (~a_eff + 1'b1) : a_eff;
        b_abs    = b_neg ? (~b_eff + 1'b1) : b_eff;
        // W operands sit in the upper half so 32 steps consume them and the
        // quotient lands in the low half.
        dvd_init = word_op_i ? {a_abs[WORD_W-1:0], {WORD_W{1'b0}}} : a_abs;
        div_zero = (b_eff == '0);
        ovf      = signed_op_i & (b_eff == '1) &
                   (a_eff == (word_op_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    end

    div_step u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd),
        .q_o   (step_q)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (request_i && !kill_i) begin
                    accept = 1'b1;
`ifdef DIV_ZERO_SHORTCUT_EN
                    state_d = (div_zero || ovf) ? ST_DONE : ST_BUSY;
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (kill_i) state_d = ST_IDLE;
    end

    // Sign fixup and special-case results.
    always_comb begin
        quo_raw = word_q ? {{(DATA_W-WORD_W){1'b0}}, dvd_q[WORD_W-1:0]} : dvd_q;
        quo_s   = quo_neg_q ? (~quo_raw + 1'b1) : quo_raw;
        rmd_s   = rmd_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (zero_q) begin
            quo_sel = '1;
            rmd_sel = orig_q;
        end else if (ovf_q) begin
            quo_sel = orig_q;
            rmd_sel = '0;
        end else begin
            quo_sel = quo_s;
            rmd_sel = rmd_s;
        end
        quo_fix = word_q ? sext_word(quo_sel[WORD_W-1:0]) : quo_sel;
        rmd_fix = word_q ? sext_word(rmd_sel[WORD_W-1:0]) : rmd_sel;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            orig_q    <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rmd_neg_q <= 1'b0;
            word_q    <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rem_q     <= '0;
                dvd_q     <= dvd_init;
                dvs_q     <= b_abs;
                orig_q    <= src1_i;
                cnt_q     <= word_op_i ? CNT_W'(ITER_W) : CNT_W'(ITER_D);
                quo_neg_q <= a_neg ^ b_neg;
                rmd_neg_q <= a_neg;
                word_q    <= word_op_i;
                zero_q    <= div_zero;
                ovf_q     <= ovf;
            end else if (state_q == ST_BUSY) begin
                rem_q <= step_rem;
                dvd_q <= step_dvd;
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == ST_DONE) begin
                quo_q <= quo_fix;
                rmd_q <= rmd_fix;
            end
        end
    end

    // Results are driven live during DONE and held afterwards.
    assign stall_o = (state_q == ST_BUSY);
    assign done_o  = (state_q == ST_DONE);
    assign quo_o   = done_o ? quo_fix : quo_q;
    assign rmd_o   = done_o ? rmd_fix : rmd_q;

endmodule

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rstn, kill, request, sop, wop;
    logic [63:0] src1, src2, quo, rmd;
    logic        stall, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .kill_i      (kill),
        .request_i   (request),
        .signed_op_i (sop),
        .word_op_i   (wop),
        .src1_i      (src1),
        .src2_i      (src2),
        .quo_o       (quo),
        .rmd_o       (rmd),
        .stall_o     (stall),
        .done_o      (done)
    );

    typedef struct {
        string       name;
        logic        s;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: RISC-V division semantics with plain arithmetic.
    function automatic logic [127:0] model(logic s, logic w, logic [63:0] a, logic [63:0] b);
        logic [31:0] a32, b32, q32, r32;
        logic [63:0] q64, r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            return {{{32{q32[31]}}, q32}, {{32{r32[31]}}, r32}};
        end
        if (b == 64'd0) begin
            q64 = '1;
            r64 = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a;
            r64 = 64'd0;
        end else if (s) begin
            q64 = $signed(a) / $signed(b);
            r64 = $signed(a) % $signed(b);
        end else begin
            q64 = a / b;
            r64 = a % b;
        end
        return {q64, r64};
    endfunction

    function automatic int exp_lat(logic s, logic w, logic [63:0] a, logic [63:0] b);
        logic zero, ovf;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
`ifdef DIV_ZERO_SHORTCUT_EN
        if (zero || ovf) return 1;
`else
        if (zero || ovf) return w ? 33 : 65;
`endif
        return w ? 33 : 65;
    endfunction

    // Issue one operation; checks latency, stall window and the done pulse.
    task automatic do_div(input string name, input logic s, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit intrude,
                          output logic [63:0] q, output logic [63:0] r);
        int lat, stalls;
        @(negedge clk);
        request = 1'b1; sop = s; wop = w; src1 = a; src2 = b;
        @(posedge clk); #1;
        request = 1'b0;
        src1 = {$urandom, $urandom};
        src2 = {$urandom, $urandom};
        lat = 0;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            lat++;
            if (done) break;
            if (stall) stalls++;
            if (intrude && lat == 5) begin
                request = 1'b1; sop = ~s; src1 = 64'd77; src2 = 64'd3;
            end else begin
                request = 1'b0;
            end
            @(posedge clk); #1;
        end
        request = 1'b0;
        q = quo;
        r = rmd;
        chk({name, ".latency"}, 64'(lat), 64'(exp_lat(s, w, a, b)));
        chk({name, ".stall_cycles"}, 64'(stalls), 64'(lat - 1));
        chk({name, ".stall_at_done"}, {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        chk({name, ".done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] q, r;
        logic [127:0] m;
        int hits;

        vecs[0]  = '{"divu_100_7",      1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2};
        vecs[1]  = '{"div_m100_7",      1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{"div_100_m7",      1'b1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2};
        vecs[3]  = '{"div_m100_m7",     1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[4]  = '{"divw_ovf",        1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0};
        vecs[5]  = '{"divu_by_zero",    1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234};
        vecs[6]  = '{"div_ovf64",       1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0};
        vecs[7]  = '{"divuw_fff0_2",    1'b0, 1'b1, 64'h1111_2222_FFFF_FFF0, 64'd2, 64'h0000_0000_7FFF_FFF8, 64'd0};
        vecs[8]  = '{"divuw_ffff_1",    1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[9]  = '{"divw_m7_zero",    1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[10] = '{"divw_upper_junk", 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0064, 64'hFFFF_FFFF_0000_0007, 64'd14, 64'd2};
        vecs[11] = '{"divu_big",        1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[12] = '{"remuw_16",        1'b0, 1'b1, 64'h0000_0000_8000_0001, 64'h10, 64'h0000_0000_0800_0000, 64'd1};
        vecs[13] = '{"div_m100_zero",   1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF9C};
        vecs[14] = '{"divu_small_big",  1'b0, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd5};

        rstn = 1'b0; kill = 1'b0; request = 1'b0; sop = 1'b0; wop = 1'b0;
        src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.stall", {63'd0, stall}, 64'd0);
        chk("reset.done",  {63'd0, done},  64'd0);
        chk("reset.quo",   quo, 64'd0);
        chk("reset.rmd",   rmd, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_div(vecs[i].name, vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].b, 1'b0, q, r);
            chk({vecs[i].name, ".quo"}, q, vecs[i].q);
            chk({vecs[i].name, ".rmd"}, r, vecs[i].r);
        end

        // Results hold after done.
        repeat (3) @(posedge clk);
        #1;
        chk("hold.quo", quo, vecs[14].q);
        chk("hold.rmd", rmd, vecs[14].r);

        // Kill at N+10, fresh request at N+11.
        @(negedge clk);
        request = 1'b1; sop = 1'b0; wop = 1'b0; src1 = 64'd1000; src2 = 64'd3;
        @(posedge clk); #1;
        request = 1'b0;
        hits = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (done) hits++;
        end
        chk("kill.stall_before", {63'd0, stall}, 64'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill.stall_after", {63'd0, stall}, 64'd0);
        chk("kill.no_done", 64'(hits + int'(done)), 64'd0);
        do_div("after_kill", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FC18, 64'd3, 1'b0, q, r);
        chk("after_kill.quo", q, 64'hFFFF_FFFF_FFFF_FEB3);
        chk("after_kill.rmd", r, 64'hFFFF_FFFF_FFFF_FFFF);

        // Request together with kill in IDLE is dropped.
        @(negedge clk);
        request = 1'b1; kill = 1'b1; src1 = 64'd50; src2 = 64'd5;
        @(posedge clk); #1;
        request = 1'b0; kill = 1'b0;
        hits = 0;
        for (int i = 0; i < 70; i++) begin
            if (done || stall) hits++;
            @(posedge clk); #1;
        end
        chk("req_kill.idle", 64'(hits), 64'd0);

        // Request while busy is ignored.
        do_div("busy_req", 1'b0, 1'b0, 64'd1000, 64'd7, 1'b1, q, r);
        chk("busy_req.quo", q, 64'd142);
        chk("busy_req.rmd", r, 64'd6);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic s, w;
            logic [63:0] a, b;
            int unsigned sel;
            s = 1'($urandom);
            w = 1'($urandom);
            a = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = w ? {$urandom, 32'd0} : 64'd0;
                1:       b = 64'($urandom_range(1, 20));
                2:       b = {32'd0, $urandom};
                3: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
                default: b = {$urandom, $urandom};
            endcase
            m = model(s, w, a, b);
            do_div($sformatf("rand%0d", i), s, w, a, b, 1'b0, q, r);
            chk($sformatf("rand%0d.quo", i), q, m[127:64]);
            chk($sformatf("rand%0d.rmd", i), r, m[63:0]);
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        request = 1'b1; sop = 1'b0; wop = 1'b0; src1 = 64'd99; src2 = 64'd4;
        @(posedge clk); #1;
        request = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst.stall", {63'd0, stall}, 64'd0);
        chk("arst.done",  {63'd0, done},  64'd0);
        chk("arst.quo",   quo, 64'd0);
        chk("arst.rmd",   rmd, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        do_div("after_arst", 1'b0, 1'b1, 64'd99, 64'd4, 1'b0, q, r);
        chk("after_arst.quo", q, 64'd24);
        chk("after_arst.rmd", r, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider in the execute stage; implements RV64M DIV/DIVU/REM/REMU and the W variants. Consumes the forwarded operands produced by the execute-stage bypass muxes. Holds the pipeline via `stall_o` while iterating, then presents quotient and remainder for one cycle toward writeback.

## Interface
Parameters:
- none; data width is `` `DATA `` (64 bits) from `definitions.vh`

Ports:
- clk_i  in  1  core clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- kill_i  in  1  flush; aborts any operation in flight
- request_i  in  1  start a division (sampled only in IDLE)
- signed_op_i  in  1  1 = DIV/REM semantics, 0 = DIVU/REMU
- word_op_i  in  1  1 = 32-bit W variant
- src1_i  in  `` `DATA ``  dividend (post-bypass)
- src2_i  in  `` `DATA ``  divisor (post-bypass)
- quo_o  out  `` `DATA ``  quotient, valid when `done_o`
- rmd_o  out  `` `DATA ``  remainder, valid when `done_o`
- stall_o  out  1  high while operation in flight (BUSY)
- done_o  out  1  one-cycle result-valid pulse

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: `request_i & ~kill_i` → latch operands, mode, iteration count → BUSY. Otherwise stay.
- Operand prep at latch: signed ops take absolute values; record quotient sign = sign(a) XOR sign(b), remainder sign = sign(a). W ops use bits [31:0] only (sign-extended for signed, zero-extended for unsigned).
- BUSY: one restoring step per cycle (shift remainder:dividend left 1, trial-subtract divisor, set quotient bit if non-negative). Counter counts 64 (or 32 for W) steps, then → DONE.
- DONE: `done_o`=1, apply sign fixup, drive `quo_o`/`rmd_o`; → IDLE next cycle. `request_i` in DONE ignored.
- Divide by zero: quo = all ones (W: sign-extended 0xFFFFFFFF), rmd = dividend.
- Signed overflow (most-negative / −1): quo = dividend, rmd = 0.
- W results: 32-bit result sign-extended to 64 bits (for both signed and unsigned).
- `kill_i` in any state → IDLE next cycle, no `done_o`; kill wins over simultaneous request.
- `request_i` while BUSY ignored.

## Timing
- Reset values: `stall_o`=0, `done_o`=0, `quo_o`=0, `rmd_o`=0; state IDLE, counter 0.
- Request accepted cycle N; BUSY cycles N+1..N+64 (W: N+1..N+32); `done_o` at N+65 (W: N+33).
- `stall_o` = (state == BUSY); low in IDLE and DONE.
- `quo_o`/`rmd_o` hold last result until next DONE; only meaningful with `done_o`.
- Reset asserted mid-operation: immediate return to reset values.

## Configuration
- `DIV_ZERO_SHORTCUT_EN` defined: divisor zero (in the effective width) skips BUSY; request at N → DONE at N+1 with divide-by-zero results; overflow case also shortcut to N+1.
- Not defined: zero divisor and overflow run full iteration count; the same architectural results still produced at N+65 / N+33.

## Structure
- `definitions.vh`: `` `DATA ``, state encodings (IDLE/BUSY/DONE), iteration count constants (64, 32), word-width constant.
- One sub-module: `div_step` — combinational single restoring iteration (inputs partial remainder, dividend bits, divisor; outputs next remainder, next dividend bits, quotient bit).

## Test plan
- DIVU 100/7, request at N → `done_o` at N+65, quo=14, rmd=2; `stall_o` high N+1..N+64.
- DIV −100/7 → quo=−14 (0xFFFF…FFF2), rmd=−2; REM sign follows dividend.
- DIVW 0x80000000/−1 → quo=0xFFFFFFFF80000000, rmd=0 at N+33; with shortcut macro at N+1.
- DIVU x/0 (x=0x1234) → quo=0xFFFF_FFFF_FFFF_FFFF, rmd=0x1234; with macro at N+1, without at N+65.
- `kill_i` at N+10 → IDLE at N+11, `done_o` never asserted, new request at N+11 accepted normally.
- Request plus kill same cycle in IDLE → stays IDLE; request during BUSY → ignored, original result unchanged.
